// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared definitions for the keypad scan controller: the
//                controller state encoding, default timing constants and
//                the key-code width.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Controller states, 2-bit explicit encoding
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } kp_state_e;

    // Defaults for a 10 MHz clock: 1 ms column step, 5 ms debounce
    localparam int c_SCAN_DIV_DEFAULT  = 10000;
    localparam int c_DB_CYCLES_DEFAULT = 50000;

    // Key code is {row[1:0], col[1:0]}
    localparam int c_KEY_CODE_W = 4;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for asynchronous inputs, parameterized
//                width. Both stages clear on synchronous reset.
//  Ports       : clk  - system clock
//                rst  - synchronous active-high reset
//                i_d  - asynchronous input bus
//                o_q  - synchronized output bus (2 cycles latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan_ctrl
//  Description : 4-column keypad scanner with press/release debouncing.
//                Steps the column drive every SCAN_DIV cycles while idle,
//                freezes it when a key is detected, and accepts a press or a
//                release only after DB_CYCLES stable cycles.
//  Ports       : clk_i        - system clock
//                rst_i        - synchronous active-high reset
//                key_det_i    - async key-detected line
//                row_code_i   - async row code of the pressed key
//                col_o        - registered column-drive code
//                key_code_o   - last accepted key {row, col}
//                key_valid_o  - one-cycle pulse on each accepted press
//                key_held_o   - high while the accepted key is pressed
//                press_cnt_o  - count of accepted presses (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = c_SCAN_DIV_DEFAULT,
    parameter int DB_CYCLES = c_DB_CYCLES_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    key_det_i,
    input  logic [1:0]              row_code_i,
    output logic [1:0]              col_o,
    output logic [c_KEY_CODE_W-1:0] key_code_o,
    output logic                    key_valid_o,
    output logic                    key_held_o,
    output logic [7:0]              press_cnt_o
);

    localparam int                 c_PRE_W  = $clog2(SCAN_DIV);
    localparam int                 c_DB_W   = $clog2(DB_CYCLES);
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(SCAN_DIV - 1);
    localparam logic [c_DB_W-1:0]  c_DB_MAX  = c_DB_W'(DB_CYCLES - 1);

    // Synchronized inputs
    logic [2:0] w_sync_out;
    logic       w_det_s;
    logic [1:0] w_row_s;

    sync_2ff #(
        .WIDTH (3)
    ) u_sync (
        .clk (clk_i),
        .rst (rst_i),
        .i_d ({key_det_i, row_code_i}),
        .o_q (w_sync_out)
    );

    assign w_det_s = w_sync_out[2];
    assign w_row_s = w_sync_out[1:0];

    // State and datapath registers
    kp_state_e                 r_state;
    logic [1:0]                r_col;
    logic [c_PRE_W-1:0]        r_pre;
    logic [c_DB_W-1:0]         r_db;
    logic [c_KEY_CODE_W-1:0]   r_code;
    logic                      r_valid;
    logic                      r_held;
    logic [7:0]                r_cnt;

    // Next-state values
    kp_state_e                 w_state_nxt;
    logic [1:0]                w_col_nxt;
    logic [c_PRE_W-1:0]        w_pre_nxt;
    logic [c_DB_W-1:0]         w_db_nxt;
    logic [c_KEY_CODE_W-1:0]   w_code_nxt;
    logic                      w_valid_nxt;
    logic                      w_held_nxt;
    logic [7:0]                w_cnt_nxt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= SCAN;
            r_col   <= '0;
            r_pre   <= '0;
            r_db    <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_held  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_pre   <= w_pre_nxt;
            r_db    <= w_db_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
            r_held  <= w_held_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_pre_nxt   = r_pre;
        w_db_nxt    = r_db;
        w_code_nxt  = r_code;
        w_valid_nxt = 1'b0;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            SCAN: begin
                if (w_det_s) begin
                    // Freeze the column that reported the key
                    w_state_nxt = PRESS_DB;
                    w_pre_nxt   = '0;
                    w_db_nxt    = '0;
                end else if (r_pre == c_PRE_MAX) begin
                    w_pre_nxt = '0;
                    w_col_nxt = r_col + 2'd1;   // 3 -> 0 wraps naturally
                end else begin
                    w_pre_nxt = r_pre + 1'b1;
                end
            end

            PRESS_DB: begin
                if (!w_det_s) begin
                    w_state_nxt = SCAN;
                    w_pre_nxt   = '0;
                end else if (r_db == c_DB_MAX) begin
                    w_state_nxt = HELD;
                    w_code_nxt  = {w_row_s, r_col};
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = r_cnt + 8'd1;
                    w_db_nxt    = '0;
                end else begin
                    w_db_nxt = r_db + 1'b1;
                end
            end

            HELD: begin
                if (!w_det_s) begin
                    w_state_nxt = REL_DB;
                    w_db_nxt    = '0;
                end
            end

            REL_DB: begin
                if (w_det_s) begin
                    // Release bounce: same key, no new press
                    w_state_nxt = HELD;
                end else if (r_db == c_DB_MAX) begin
                    w_state_nxt = SCAN;
                    w_pre_nxt   = '0;
                    w_db_nxt    = '0;
                end else begin
                    w_db_nxt = r_db + 1'b1;
                end
            end

            default: begin
                w_state_nxt = SCAN;
            end
        endcase

        // Registered so it rises together with key_valid_o
        w_held_nxt = (w_state_nxt == HELD) || (w_state_nxt == REL_DB);
    end

    assign col_o       = r_col;
    assign key_code_o  = r_code;
    assign key_valid_o = r_valid;
    assign key_held_o  = r_held;
    assign press_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scan_ctrl
//  Description : Self-checking bench for keypad_scan_ctrl with SCAN_DIV=4,
//                DB_CYCLES=8. A run-length reference model predicts every
//                output on every clock; directed checks cover the reset,
//                press, glitch, bounce and counter-wrap cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV  = 4;
    localparam int DB_CYCLES = 8;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       key_det_i;
    logic [1:0] row_code_i;
    logic [1:0] col_o;
    logic [3:0] key_code_o;
    logic       key_valid_o;
    logic       key_held_o;
    logic [7:0] press_cnt_o;

    always #5 clk_i = ~clk_i;

    keypad_scan_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .key_det_i   (key_det_i),
        .row_code_i  (row_code_i),
        .col_o       (col_o),
        .key_code_o  (key_code_o),
        .key_valid_o (key_valid_o),
        .key_held_o  (key_held_o),
        .press_cnt_o (press_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    int dut_pulses = 0;

    // Reference model: input delay line plus run-length counters
    int m_det_q[$];
    int m_row_q[$];
    int m_held;
    int m_high_run;
    int m_low_run;
    int m_base;
    int m_ticks;
    int m_cnt;
    int m_code;
    int m_valid;

    // Column is the frozen base plus one step per SCAN_DIV idle cycles
    function automatic int m_col();
        return (m_base + m_ticks / SCAN_DIV) % 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_det_q    = '{0, 0};
        m_row_q    = '{0, 0};
        m_held     = 0;
        m_high_run = 0;
        m_low_run  = 0;
        m_base     = 0;
        m_ticks    = 0;
        m_cnt      = 0;
        m_code     = 0;
        m_valid    = 0;
    endtask

    task automatic model_step();
        int det_s;
        int row_s;
        det_s = m_det_q.pop_front();
        row_s = m_row_q.pop_front();
        m_det_q.push_back(int'(key_det_i));
        m_row_q.push_back(int'(row_code_i));
        m_valid = 0;
        if (m_held == 0) begin
            if (det_s != 0) begin
                m_high_run++;
                if (m_high_run == 1) begin
                    m_base  = m_col();
                    m_ticks = 0;
                end
                // Detection cycle plus DB_CYCLES debounce cycles
                if (m_high_run == DB_CYCLES + 1) begin
                    m_code     = row_s * 4 + m_col();
                    m_valid    = 1;
                    m_cnt      = (m_cnt + 1) % 256;
                    m_held     = 1;
                    m_high_run = 0;
                    m_low_run  = 0;
                end
            end else if (m_high_run > 0) begin
                m_high_run = 0;
            end else begin
                m_ticks++;
            end
        end else begin
            if (det_s != 0) begin
                m_low_run = 0;
            end else begin
                m_low_run++;
                if (m_low_run == DB_CYCLES + 1) begin
                    m_held    = 0;
                    m_low_run = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (rst_i) model_reset();
        else       model_step();
        #1;
        if (key_valid_o === 1'b1) dut_pulses++;
        check("col",   32'(col_o),       32'(m_col()));
        check("code",  32'(key_code_o),  32'(m_code));
        check("valid", 32'(key_valid_o), 32'(m_valid));
        check("held",  32'(key_held_o),  32'(m_held));
        check("cnt",   32'(press_cnt_o), 32'(m_cnt));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic det, input logic [1:0] row);
        key_det_i  = det;
        row_code_i = row;
    endtask

    initial begin
        int w;
        int base_pulses;
        model_reset();
        rst_i = 1'b1;
        drive(1'b0, 2'd0);

        // Reset state
        run(3);
        check("rst_col",   32'(col_o),       32'd0);
        check("rst_code",  32'(key_code_o),  32'd0);
        check("rst_valid", 32'(key_valid_o), 32'd0);
        check("rst_held",  32'(key_held_o),  32'd0);
        check("rst_cnt",   32'(press_cnt_o), 32'd0);
        rst_i = 1'b0;

        // Idle scan: col steps every SCAN_DIV cycles, no pulses
        run(18);
        check("idle_pulses", 32'(dut_pulses), 32'd0);

        // Press row 2 on column 1, detected right after col becomes 1
        w = 0;
        while (m_col() == 1 && w < 16) begin tick(); w++; end
        w = 0;
        while (m_col() != 1 && w < 16) begin tick(); w++; end
        check("wait_col1", 32'(col_o), 32'd1);
        drive(1'b1, 2'd2);
        run(20);
        check("press_code",   32'(key_code_o),  32'h9);
        check("press_cnt",    32'(press_cnt_o), 32'd1);
        check("press_held",   32'(key_held_o),  32'd1);
        check("press_col",    32'(col_o),       32'd1);
        check("press_pulses", 32'(dut_pulses),  32'd1);
        drive(1'b0, 2'd0);
        run(20);
        check("release_held", 32'(key_held_o),  32'd0);

        // 5-cycle glitch: never accepted
        drive(1'b1, 2'd3);
        run(5);
        drive(1'b0, 2'd0);
        run(12);
        check("glitch_pulses", 32'(dut_pulses),  32'd1);
        check("glitch_cnt",    32'(press_cnt_o), 32'd1);

        // Press, then release with a 3-cycle bounce
        drive(1'b1, 2'd0);
        run(14);
        drive(1'b0, 2'd0);
        run(4);
        drive(1'b1, 2'd0);
        run(3);
        drive(1'b0, 2'd0);
        run(10);
        check("bounce_held_still", 32'(key_held_o), 32'd1);
        run(1);
        check("bounce_held_drop",  32'(key_held_o), 32'd0);
        check("bounce_pulses",     32'(dut_pulses), 32'd2);
        run(8);

        // Random segments of key activity
        for (int s = 0; s < 150; s++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            run($urandom_range(1, 14));
        end
        drive(1'b0, 2'd0);
        run(20);

        // Reset in the middle of press debounce
        drive(1'b1, 2'd1);
        run(6);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rstdb_valid", 32'(key_valid_o), 32'd0);
        check("rstdb_cnt",   32'(press_cnt_o), 32'd0);
        check("rstdb_col",   32'(col_o),       32'd0);
        tick();
        check("rstdb_valid_after", 32'(key_valid_o), 32'd0);

        // Reset while a key is held
        run(14);
        check("pre_rst_held", 32'(key_held_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rsth_held",  32'(key_held_o),  32'd0);
        check("rsth_code",  32'(key_code_o),  32'd0);
        check("rsth_valid", 32'(key_valid_o), 32'd0);
        check("rsth_cnt",   32'(press_cnt_o), 32'd0);
        drive(1'b0, 2'd0);
        run(15);

        // 256 accepted presses from reset: counter wraps to 0
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        base_pulses = dut_pulses;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 2'(i % 4));
            run(14);
            drive(1'b0, 2'd0);
            run(14);
            if (i == 254) check("wrap_cnt_255", 32'(press_cnt_o), 32'd255);
        end
        check("wrap_cnt_0",   32'(press_cnt_o),             32'd0);
        check("wrap_pulses",  32'(dut_pulses - base_pulses), 32'd256);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
